pir_sample_conditioner: RTL and testbench

Upstream conditioning stage for the PIR motion controller. It accepts raw 8-bit PIR samples tagged with a channel number over a valid/ready handshake and keeps a per-channel moving average. Each average is clipped and driven as the three 7-bit `pir_level_*` buses that feed the controller's `pir_sensor_1..3` inputs. Channels that stop reporting are flagged stale and forced to zero, so a dead sensor never holds a motion level.

---
 rtl/pir_sample_conditioner_if.sv | 9 +
 rtl/pir_sample_conditioner.sv | 128 ++++++++++++
 tb/tb_pir_sample_conditioner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pir_sample_conditioner_if.sv
// pir_sample_conditioner_if: valid/ready bus carrying channel-tagged raw PIR samples.
interface pir_sample_conditioner_if;
    logic       sample_valid;
    logic       sample_ready;
    logic [1:0] sample_ch;
    logic [7:0] sample_data;
    modport master (output sample_valid, sample_ch, sample_data, input sample_ready);
    modport slave (input sample_valid, sample_ch, sample_data, output sample_ready);
endinterface

// File: rtl/pir_sample_conditioner.sv
// pir_sample_conditioner: per-channel moving average, clip and stale timeout of raw PIR samples.
// Optional outlier rejection is enabled by defining PIR_COND_SPIKE_REJECT_EN.
module pir_sample_conditioner #(
    parameter int AVG_LOG2     = 2,
    parameter int LEVEL_MAX    = 100,
    parameter int STALE_CYCLES = 1000,
    parameter int SPIKE_DELTA  = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pir_sample_conditioner_if.slave bus,
    output logic [6:0]              pir_level_1,
    output logic [6:0]              pir_level_2,
    output logic [6:0]              pir_level_3,
    output logic                    level_update,
    output logic [2:0]              stale,
    output logic                    bad_ch,
    output logic                    spike_drop
);
    localparam int WIN = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam logic [7:0] LMAX = 8'(LEVEL_MAX);
    localparam logic [CW-1:0] SMAX = CW'(STALE_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t              state, next_state;
    logic [1:0]          lch;
    logic [7:0]          ldata;
    logic [7:0]          win [3][WIN];
    logic [AVG_LOG2-1:0] ptr [3];
    logic [SW-1:0]       sum [3];
    logic [7:0]          avg [3];
    logic [CW-1:0]       cnt [3];
    logic [1:0]          idx;
    logic [7:0]          new_avg;
    logic                spike;

    function automatic logic [6:0] clip(input logic [7:0] a);
        return a > LMAX ? LMAX[6:0] : a[6:0];
    endfunction

    assign idx = lch - 2'd1;
    assign new_avg = 8'(sum[idx] >> AVG_LOG2);

    // A stale channel reads zero while its window and average are preserved.
    assign pir_level_1 = stale[0] ? 7'd0 : clip(avg[0]);
    assign pir_level_2 = stale[1] ? 7'd0 : clip(avg[1]);
    assign pir_level_3 = stale[2] ? 7'd0 : clip(avg[2]);

`ifdef PIR_COND_SPIKE_REJECT_EN
    localparam logic [7:0] SDELTA = 8'(SPIKE_DELTA);
    logic [2:0] rej;
    logic [7:0] dist;
    assign dist = ldata > avg[idx] ? ldata - avg[idx] : avg[idx] - ldata;
    assign spike = lch != 2'd0 && dist > SDELTA && !rej[idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rej <= '0;
        else if (state == ACCUM && lch != 2'd0)
            rej[idx] <= spike;
    end
`else
    assign spike = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        bus.sample_ready = state == IDLE;
        case (state)
            IDLE:    next_state = bus.sample_valid ? ACCUM : IDLE;
            ACCUM:   next_state = (lch == 2'd0 || spike) ? IDLE : UPDATE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lch <= '0;
            ldata <= '0;
            level_update <= 1'b0;
            bad_ch <= 1'b0;
            spike_drop <= 1'b0;
            stale <= '0;
            for (int i = 0; i < 3; i++) begin
                ptr[i] <= '0;
                sum[i] <= '0;
                avg[i] <= '0;
                cnt[i] <= '0;
                for (int j = 0; j < WIN; j++)
                    win[i][j] <= '0;
            end
        end else begin
            level_update <= state == UPDATE;
            bad_ch <= state == ACCUM && lch == 2'd0;
            spike_drop <= state == ACCUM && spike;
            if (state == IDLE && bus.sample_valid) begin
                lch <= bus.sample_ch;
                ldata <= bus.sample_data;
            end
            for (int i = 0; i < 3; i++) begin
                if (cnt[i] != SMAX)
                    cnt[i] <= cnt[i] + 1'b1;
                if (cnt[i] == SMAX - 1'b1)
                    stale[i] <= 1'b1;
            end
            if (state == ACCUM && lch != 2'd0 && !spike) begin
                sum[idx] <= sum[idx] - SW'(win[idx][ptr[idx]]) + SW'(ldata);
                win[idx][ptr[idx]] <= ldata;
                ptr[idx] <= ptr[idx] + 1'b1;
            end
            // Placed after the timers so a same-cycle expiry loses to the fresh sample.
            if (state == UPDATE) begin
                avg[idx] <= new_avg;
                cnt[idx] <= '0;
                stale[idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pir_sample_conditioner.sv
// tb_pir_sample_conditioner: table-driven check of averaging, clipping, channel-0 drop and stale timing.
module tb_pir_sample_conditioner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] l1, l2, l3;
    logic upd, bad, spk;
    logic [2:0] stl;
    int total = 0;
    int nbad = 0;

    typedef struct {int ch; int data; int l1; int l2; int l3; int sp;} vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pir_sample_conditioner_if sif();

    pir_sample_conditioner dut (
        .clk(clk), .rst_n(rst_n), .bus(sif),
        .pir_level_1(l1), .pir_level_2(l2), .pir_level_3(l3),
        .level_update(upd), .stale(stl), .bad_ch(bad), .spike_drop(spk)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that follows the result.
    task automatic apply(input vec_t v);
        bit drop;
        drop = v.ch == 0 || v.sp != 0;
        sif.sample_valid = 1'b1;
        sif.sample_ch = 2'(v.ch);
        sif.sample_data = 8'(v.data);
        @(posedge clk); #1;
        sif.sample_valid = 1'b0;
        sif.sample_data = 8'hA5;
        sif.sample_ch = 2'd0;
        chk("ready_accum", int'(sif.sample_ready), 0);
        @(posedge clk); #1;
        chk("bad_ch", int'(bad), int'(v.ch == 0));
        chk("spike_drop", int'(spk), v.sp);
        chk("ready_after_accum", int'(sif.sample_ready), int'(drop));
        if (!drop) begin
            @(posedge clk); #1;
            chk("ready_after_update", int'(sif.sample_ready), 1);
        end
        chk("level_update", int'(upd), int'(!drop));
        chk("level_1", int'(l1), v.l1);
        chk("level_2", int'(l2), v.l2);
        chk("level_3", int'(l3), v.l3);
        @(posedge clk); #1;
        chk("pulses_clear", int'({upd, bad, spk}), 0);
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_ch = 2'd0;
        sif.sample_data = 8'd0;
`ifdef PIR_COND_SPIKE_REJECT_EN
        vecs.push_back('{1, 50, 0, 0, 0, 1});
        vecs.push_back('{1, 50, 12, 0, 0, 0});
        vecs.push_back('{1, 50, 25, 0, 0, 0});
        vecs.push_back('{1, 50, 37, 0, 0, 0});
        vecs.push_back('{1, 50, 50, 0, 0, 0});
        vecs.push_back('{0, 9, 50, 0, 0, 0});
        vecs.push_back('{1, 200, 50, 0, 0, 1});
        vecs.push_back('{1, 200, 87, 0, 0, 0});
`else
        vecs.push_back('{1, 200, 50, 0, 0, 0});
        vecs.push_back('{2, 255, 50, 63, 0, 0});
        vecs.push_back('{2, 255, 50, 100, 0, 0});
        vecs.push_back('{2, 255, 50, 100, 0, 0});
        vecs.push_back('{2, 255, 50, 100, 0, 0});
        vecs.push_back('{2, 0, 50, 100, 0, 0});
        vecs.push_back('{0, 77, 50, 100, 0, 0});
        vecs.push_back('{1, 0, 50, 100, 0, 0});
        vecs.push_back('{1, 40, 60, 100, 0, 0});
        vecs.push_back('{2, 4, 60, 100, 0, 0});
        vecs.push_back('{2, 4, 60, 65, 0, 0});
        vecs.push_back('{1, 1, 60, 65, 0, 0});
        vecs.push_back('{3, 3, 60, 65, 0, 0});
        vecs.push_back('{3, 252, 60, 65, 63, 0});
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(sif.sample_ready), 1);
        chk("rst_levels", int'({l1, l2, l3}), 0);
        chk("rst_stale", int'(stl), 0);
        chk("rst_pulses", int'({upd, bad, spk}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Reset while a sample is in flight must discard it.
        sif.sample_valid = 1'b1;
        sif.sample_ch = 2'd1;
        sif.sample_data = 8'd200;
        @(posedge clk); #1;
        sif.sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(sif.sample_ready), 1);
        chk("midrst_levels", int'({l1, l2, l3}), 0);
        chk("midrst_stale", int'(stl), 0);
        @(negedge clk) rst_n = 1'b1;

        // Counters run from reset release; a ch1 UPDATE lands on the expiry edge (1000).
        repeat (997) @(posedge clk);
        #1;
        chk("lost_sample_level_1", int'(l1), 0);
        chk("pre_expiry_stale", int'(stl), 0);
        sif.sample_valid = 1'b1;
        sif.sample_ch = 2'd1;
        sif.sample_data = 8'd40;
        @(posedge clk); #1;
        sif.sample_valid = 1'b0;
        @(posedge clk); #1;
        chk("stale_at_999", int'(stl), 0);
        @(posedge clk); #1;
        chk("stale_at_1000", int'(stl), 3'b110);
        chk("collision_level_1", int'(l1), 10);
        chk("collision_update", int'(upd), 1);
        chk("stale_level_3", int'(l3), 0);
`ifndef PIR_COND_SPIKE_REJECT_EN
        apply('{3, 80, 10, 0, 20, 0});
        chk("revived_stale", int'(stl), 3'b010);
`endif
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
